// File: rtl/decentral_demux.sv
// rtl/decentral_demux.sv - registered write distributor with single writes and auto-incrementing bursts
module decentral_demux #(
    parameter int DATA_WIDTH = 1,
    parameter int ADR_WIDTH  = 8,
    parameter int NINPUTS    = 16
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic [ADR_WIDTH-1:0]          SELECT_I,
    input  logic [DATA_WIDTH-1:0]         DATA_I,
    input  logic                          WR_I,
    input  logic                          START_I,
    input  logic [ADR_WIDTH-1:0]          COUNT_I,
    input  logic                          VALID_I,
    output logic                          READY_O,
    input  logic                          CLEAR_I,
    output logic [NINPUTS*DATA_WIDTH-1:0] DATA_O,
    output logic                          BUSY_O,
    output logic                          DONE_O,
    output logic                          ERR_O
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so NINPUTS == 2**ADR_WIDTH still compares correctly.
    localparam logic [ADR_WIDTH:0]   NSLOTS    = (ADR_WIDTH+1)'(NINPUTS);
    localparam logic [ADR_WIDTH-1:0] LAST_SLOT = ADR_WIDTH'(NINPUTS - 1);

    state_t                        state, state_n;
    logic [ADR_WIDTH-1:0]          ptr, ptr_n;
    logic [ADR_WIDTH-1:0]          rem, rem_n;
    logic [NINPUTS*DATA_WIDTH-1:0] slots;
    logic                          err;

    logic                          sel_ok;
    logic                          wr_en;
    logic [ADR_WIDTH-1:0]          wr_idx;
    logic                          err_set;

    assign sel_ok = ({1'b0, SELECT_I} < NSLOTS);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (START_I) begin
                    if (!sel_ok) begin
                        err_set = 1'b1;
                    end else begin
                        ptr_n   = SELECT_I;
                        rem_n   = COUNT_I;
                        state_n = (COUNT_I == '0) ? DONE : BURST;
                    end
                end else if (WR_I) begin
                    if (sel_ok) begin
                        wr_en  = 1'b1;
                        wr_idx = SELECT_I;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            BURST: begin
                if (VALID_I) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr;
                    ptr_n  = (ptr == LAST_SLOT) ? '0 : ptr + ADR_WIDTH'(1);
                    rem_n  = rem - ADR_WIDTH'(1);
                    if (rem == ADR_WIDTH'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            slots <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            rem   <= rem_n;
            err   <= err_set | (err & ~CLEAR_I);
            // Clear beats a coincident write; the burst pointer still advances above.
            if (CLEAR_I) begin
                slots <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NINPUTS; i++) begin
                    if (wr_idx == ADR_WIDTH'(i)) begin
                        slots[i*DATA_WIDTH +: DATA_WIDTH] <= DATA_I;
                    end
                end
            end
        end
    end

    assign DATA_O  = slots;
    assign READY_O = (state == BURST);
    assign BUSY_O  = (state != IDLE);
    assign DONE_O  = (state == DONE);
    assign ERR_O   = err;

endmodule

// File: tb/tb_decentral_demux.sv
// tb/tb_decentral_demux.sv - directed self-checking bench for decentral_demux
module tb_decentral_demux;

    localparam int DW = 4;
    localparam int AW = 8;
    localparam int NI = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     select;
    logic [DW-1:0]     data_in;
    logic              wr;
    logic              start;
    logic [AW-1:0]     count;
    logic              valid;
    logic              ready;
    logic              clear;
    logic [NI*DW-1:0]  data_out;
    logic              busy;
    logic              done;
    logic              err;

    logic [NI*DW-1:0]  exp_data;
    int                checks   = 0;
    int                failures = 0;

    decentral_demux #(
        .DATA_WIDTH(DW),
        .ADR_WIDTH (AW),
        .NINPUTS   (NI)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .SELECT_I(select),
        .DATA_I  (data_in),
        .WR_I    (wr),
        .START_I (start),
        .COUNT_I (count),
        .VALID_I (valid),
        .READY_O (ready),
        .CLEAR_I (clear),
        .DATA_O  (data_out),
        .BUSY_O  (busy),
        .DONE_O  (done),
        .ERR_O   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; select = '0; data_in = '0; wr = 1'b0; start = 1'b0;
        count = '0; valid = 1'b0; clear = 1'b0;
        exp_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_data", data_out, 64'h0);
        chk("reset_ready", 64'(ready), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_err", 64'(err), 64'h0);

        // single writes
        select = 8'd3; data_in = 4'hA; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_data[15:12] = 4'hA;
        chk("wr3_data", data_out, exp_data);
        chk("wr3_busy", 64'(busy), 64'h0);
        select = 8'd15; data_in = 4'h5; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_data[63:60] = 4'h5;
        chk("wr15_data", data_out, exp_data);
        chk("wr15_busy", 64'(busy), 64'h0);

        // burst with wrap, VALID pattern 1,0,1,1,1
        select = 8'd14; count = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("burst_busy", 64'(busy), 64'h1);
        chk("burst_ready0", 64'(ready), 64'h1);
        valid = 1'b1; data_in = 4'h1;
        tick();
        exp_data[59:56] = 4'h1;
        chk("burst_w1", data_out, exp_data);
        chk("burst_ready1", 64'(ready), 64'h1);
        valid = 1'b0;
        tick();
        chk("burst_hold_data", data_out, exp_data);
        chk("burst_hold_ready", 64'(ready), 64'h1);
        chk("burst_hold_done", 64'(done), 64'h0);
        valid = 1'b1; data_in = 4'h2;
        tick();
        exp_data[63:60] = 4'h2;
        chk("burst_w2", data_out, exp_data);
        data_in = 4'h3;
        tick();
        exp_data[3:0] = 4'h3;
        chk("burst_w3_wrap", data_out, exp_data);
        chk("burst_ready3", 64'(ready), 64'h1);
        chk("burst_done_early", 64'(done), 64'h0);
        data_in = 4'h4;
        tick();
        valid = 1'b0;
        exp_data[7:4] = 4'h4;
        chk("burst_w4", data_out, exp_data);
        chk("burst_done", 64'(done), 64'h1);
        chk("burst_done_ready", 64'(ready), 64'h0);
        chk("burst_done_busy", 64'(busy), 64'h1);
        tick();
        chk("burst_end_done", 64'(done), 64'h0);
        chk("burst_end_busy", 64'(busy), 64'h0);

        // out of range addresses
        select = 8'd16; data_in = 4'hF; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("oor_wr_err", 64'(err), 64'h1);
        chk("oor_wr_data", data_out, exp_data);
        select = 8'd200; count = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("oor_start_busy", 64'(busy), 64'h0);
        chk("oor_start_err", 64'(err), 64'h1);
        chk("oor_start_data", data_out, exp_data);
        tick();
        chk("err_sticky", 64'(err), 64'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_data = '0;
        chk("clear_data", data_out, exp_data);
        chk("clear_err", 64'(err), 64'h0);

        // clear together with a new error: set wins
        select = 8'd20; wr = 1'b1; clear = 1'b1;
        tick();
        wr = 1'b0; clear = 1'b0;
        chk("clear_set_err", 64'(err), 64'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_again_err", 64'(err), 64'h0);

        // WR_I and START_I together: burst wins
        select = 8'd2; data_in = 4'h7; count = 8'd1; wr = 1'b1; start = 1'b1;
        tick();
        wr = 1'b0; start = 1'b0;
        chk("both_busy", 64'(busy), 64'h1);
        chk("both_no_write", data_out, exp_data);
        valid = 1'b1; data_in = 4'h9;
        tick();
        valid = 1'b0;
        exp_data[11:8] = 4'h9;
        chk("both_burst_data", data_out, exp_data);
        chk("both_done", 64'(done), 64'h1);
        tick();
        chk("both_idle", 64'(busy), 64'h0);

        // zero-length burst
        select = 8'd5; count = 8'd0; start = 1'b1; data_in = 4'hC;
        tick();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'h1);
        chk("zero_ready", 64'(ready), 64'h0);
        chk("zero_data", data_out, exp_data);
        tick();
        chk("zero_done_end", 64'(done), 64'h0);
        chk("zero_busy_end", 64'(busy), 64'h0);

        // CLEAR_I during a burst transfer
        select = 8'd0; count = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1; data_in = 4'h6; clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_data = '0;
        chk("clrb_data", data_out, exp_data);
        chk("clrb_ready", 64'(ready), 64'h1);
        data_in = 4'h8;
        tick();
        valid = 1'b0;
        exp_data[7:4] = 4'h8;
        chk("clrb_ptr_adv", data_out, exp_data);
        chk("clrb_rem_done", 64'(done), 64'h1);
        tick();

        // reset mid-burst
        select = 8'd4; count = 8'd8; start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            data_in = DW'(i);
            tick();
        end
        exp_data[19:16] = 4'h1;
        exp_data[23:20] = 4'h2;
        exp_data[27:24] = 4'h3;
        chk("mid_data", data_out, exp_data);
        chk("mid_busy", 64'(busy), 64'h1);
        valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_data = '0;
        chk("rst_mid_data", data_out, exp_data);
        chk("rst_mid_ready", 64'(ready), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_done", 64'(done), 64'h0);
        tick();
        chk("rst_mid_no_done", 64'(done), 64'h0);
        chk("rst_mid_idle", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
